// File: rtl/regfile_access_arbiter.sv
// Round-robin arbiter sharing one register file between the core (requester 0)
// and the debug/loader port (requester 1), sequencing around the one-cycle read latency.
module regfile_access_arbiter #(
  parameter int memoryDepth     = 16,
  parameter int addressBitWidth = 4,
  parameter int dataBitWidth    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req0,
  input  logic                       req1,
  input  logic                       we0,
  input  logic                       we1,
  input  logic                       rs_use0,
  input  logic                       rs_use1,
  input  logic [addressBitWidth-1:0] rd_addr0,
  input  logic [addressBitWidth-1:0] rd_addr1,
  input  logic [addressBitWidth-1:0] rs_addr0,
  input  logic [addressBitWidth-1:0] rs_addr1,
  input  logic [dataBitWidth-1:0]    wdata0,
  input  logic [dataBitWidth-1:0]    wdata1,
  output logic                       gnt0,
  output logic                       gnt1,
  output logic                       done,
  output logic                       rsp_id,
  output logic [dataBitWidth-1:0]    rsp_rd_data,
  output logic [dataBitWidth-1:0]    rsp_rs_data,
  output logic                       rsp_err,
  output logic                       rf_rd_en,
  output logic                       rf_rs_en,
  output logic                       rf_wr_en,
  output logic [addressBitWidth-1:0] rf_rd_addr,
  output logic [addressBitWidth-1:0] rf_rs_addr,
  output logic [dataBitWidth-1:0]    rf_wr_data,
  input  logic [dataBitWidth-1:0]    rf_rd_data,
  input  logic [dataBitWidth-1:0]    rf_rs_data,
  input  logic                       rf_valid
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPT, DONE} state_t;

  state_t                     state_reg;
  logic                       last_gnt_reg;
  logic                       owner_reg;
  logic                       is_write_reg;
  logic                       rs_use_reg;
  logic                       err_reg;
  logic                       gnt0_reg;
  logic                       gnt1_reg;
  logic                       done_reg;
  logic                       rsp_id_reg;
  logic                       rsp_err_reg;
  logic [dataBitWidth-1:0]    rsp_rd_data_reg;
  logic [dataBitWidth-1:0]    rsp_rs_data_reg;
  logic                       rf_rd_en_reg;
  logic                       rf_rs_en_reg;
  logic                       rf_wr_en_reg;
  logic [addressBitWidth-1:0] rf_rd_addr_reg;
  logic [addressBitWidth-1:0] rf_rs_addr_reg;
  logic [dataBitWidth-1:0]    rf_wr_data_reg;

  logic                       pick1;
  logic                       sel_we;
  logic                       sel_rs_use;
  logic [addressBitWidth-1:0] sel_rd_addr;
  logic [addressBitWidth-1:0] sel_rs_addr;
  logic [dataBitWidth-1:0]    sel_wdata;
  logic                       sel_rd_ok;
  logic                       sel_rs_ok;

  // Addresses are two's complement; only 0 <= addr < memoryDepth is a real register.
  function automatic logic addr_ok(input logic [addressBitWidth-1:0] addr);
    int addr_val;
    addr_val = int'($signed(addr));
    return (addr_val >= 0) && (addr_val < memoryDepth);
  endfunction

  // On a tie the requester that was not granted last wins.
  always_comb begin
    pick1       = req1 && (!req0 || !last_gnt_reg);
    sel_we      = pick1 ? we1      : we0;
    sel_rs_use  = pick1 ? rs_use1  : rs_use0;
    sel_rd_addr = pick1 ? rd_addr1 : rd_addr0;
    sel_rs_addr = pick1 ? rs_addr1 : rs_addr0;
    sel_wdata   = pick1 ? wdata1   : wdata0;
    sel_rd_ok   = addr_ok(sel_rd_addr);
    sel_rs_ok   = addr_ok(sel_rs_addr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      last_gnt_reg    <= 1'b1;
      owner_reg       <= 1'b0;
      is_write_reg    <= 1'b0;
      rs_use_reg      <= 1'b0;
      err_reg         <= 1'b0;
      gnt0_reg        <= 1'b0;
      gnt1_reg        <= 1'b0;
      done_reg        <= 1'b0;
      rsp_id_reg      <= 1'b0;
      rsp_err_reg     <= 1'b0;
      rsp_rd_data_reg <= '0;
      rsp_rs_data_reg <= '0;
      rf_rd_en_reg    <= 1'b0;
      rf_rs_en_reg    <= 1'b0;
      rf_wr_en_reg    <= 1'b0;
      rf_rd_addr_reg  <= '0;
      rf_rs_addr_reg  <= '0;
      rf_wr_data_reg  <= '0;
    end else begin
      gnt0_reg     <= 1'b0;
      gnt1_reg     <= 1'b0;
      done_reg     <= 1'b0;
      rf_rd_en_reg <= 1'b0;
      rf_rs_en_reg <= 1'b0;
      rf_wr_en_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req0 || req1) begin
            owner_reg      <= pick1;
            last_gnt_reg   <= pick1;
            gnt0_reg       <= !pick1;
            gnt1_reg       <= pick1;
            is_write_reg   <= sel_we;
            rs_use_reg     <= !sel_we && sel_rs_use;
            rf_rd_addr_reg <= sel_rd_addr;
            rf_rs_addr_reg <= sel_rs_addr;
            rf_wr_data_reg <= sel_wdata;
            err_reg        <= !sel_rd_ok || (!sel_we && sel_rs_use && !sel_rs_ok);
            // An out-of-range write is suppressed entirely, reported only via rsp_err.
            rf_wr_en_reg   <= sel_we && sel_rd_ok;
            rf_rd_en_reg   <= !sel_we;
            rf_rs_en_reg   <= !sel_we && sel_rs_use;
            state_reg      <= ISSUE;
          end
        end
        ISSUE: begin
          if (is_write_reg) begin
            done_reg    <= 1'b1;
            rsp_id_reg  <= owner_reg;
            rsp_err_reg <= err_reg;
            state_reg   <= DONE;
          end else begin
            state_reg   <= CAPT;
          end
        end
        CAPT: begin
          rsp_rd_data_reg <= rf_rd_data;
          rsp_rs_data_reg <= rs_use_reg ? rf_rs_data : '0;
          rsp_err_reg     <= err_reg || !rf_valid;
          rsp_id_reg      <= owner_reg;
          done_reg        <= 1'b1;
          state_reg       <= DONE;
        end
        DONE: state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign gnt0        = gnt0_reg;
  assign gnt1        = gnt1_reg;
  assign done        = done_reg;
  assign rsp_id      = rsp_id_reg;
  assign rsp_err     = rsp_err_reg;
  assign rsp_rd_data = rsp_rd_data_reg;
  assign rsp_rs_data = rsp_rs_data_reg;
  assign rf_rd_en    = rf_rd_en_reg;
  assign rf_rs_en    = rf_rs_en_reg;
  assign rf_wr_en    = rf_wr_en_reg;
  assign rf_rd_addr  = rf_rd_addr_reg;
  assign rf_rs_addr  = rf_rs_addr_reg;
  assign rf_wr_data  = rf_wr_data_reg;

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Directed bench for regfile_access_arbiter with a one-cycle-latency register file model.
module tb_regfile_access_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1, rs_use0, rs_use1;
  logic [3:0]  rd_addr0, rd_addr1, rs_addr0, rs_addr1;
  logic [15:0] wdata0, wdata1;
  logic        gnt0, gnt1, done, rsp_id, rsp_err;
  logic [15:0] rsp_rd_data, rsp_rs_data;
  logic        rf_rd_en, rf_rs_en, rf_wr_en;
  logic [3:0]  rf_rd_addr, rf_rs_addr;
  logic [15:0] rf_wr_data, rf_rd_data, rf_rs_data;
  logic        rf_valid;
  logic [15:0] mem [16];

  int errors = 0;
  int checks = 0;

  regfile_access_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .rs_use0(rs_use0), .rs_use1(rs_use1),
    .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .rs_addr0(rs_addr0), .rs_addr1(rs_addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done(done), .rsp_id(rsp_id),
    .rsp_rd_data(rsp_rd_data), .rsp_rs_data(rsp_rs_data), .rsp_err(rsp_err),
    .rf_rd_en(rf_rd_en), .rf_rs_en(rf_rs_en), .rf_wr_en(rf_wr_en),
    .rf_rd_addr(rf_rd_addr), .rf_rs_addr(rf_rs_addr), .rf_wr_data(rf_wr_data),
    .rf_rd_data(rf_rd_data), .rf_rs_data(rf_rs_data), .rf_valid(rf_valid)
  );

  always #5 clk = ~clk;

  // Register file: synchronous write, one-cycle registered reads.
  always @(posedge clk) begin
    if (rf_wr_en) mem[rf_rd_addr] <= rf_wr_data;
    if (rf_rd_en) rf_rd_data <= mem[rf_rd_addr];
    if (rf_rs_en) rf_rs_data <= mem[rf_rs_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Exclusivity rules checked every cycle outside reset.
  always begin
    @(posedge clk);
    #1;
    if (!rst)
      chk("exclusive", {29'd0, gnt0 && gnt1, done && (gnt0 || gnt1),
                        rf_wr_en && (rf_rd_en || rf_rs_en)}, 32'd0);
  end

  // Issue one operation from idle; returns one cycle after done, FSM back in IDLE.
  task automatic op(input string tag, input bit id, input bit we, input bit rsu,
                    input logic [3:0] rd, input logic [3:0] rs, input logic [15:0] wd,
                    input bit exp_err, input logic [15:0] exp_rd, input logic [15:0] exp_rs);
    int n;
    bit saw_wr, saw_rs, exp_wr;
    exp_wr = we && !exp_err;
    if (!id) begin req0 = 1; we0 = we; rs_use0 = rsu; rd_addr0 = rd; rs_addr0 = rs; wdata0 = wd; end
    else     begin req1 = 1; we1 = we; rs_use1 = rsu; rd_addr1 = rd; rs_addr1 = rs; wdata1 = wd; end
    @(posedge clk); #1;
    chk({tag, "_gnt_own"}, id ? gnt1 : gnt0, 1);
    chk({tag, "_gnt_oth"}, id ? gnt0 : gnt1, 0);
    chk({tag, "_issue_en"}, {rf_wr_en, rf_rd_en, rf_rs_en}, {exp_wr, !we, !we && rsu});
    chk({tag, "_issue_addr"}, rf_rd_addr, rd);
    if (exp_wr) chk({tag, "_wdata"}, rf_wr_data, wd);
    req0 = 0; req1 = 0;
    saw_wr = rf_wr_en; saw_rs = rf_rs_en; n = 0;
    while (!done && n < 8) begin
      @(posedge clk); #1;
      n++;
      saw_wr |= rf_wr_en; saw_rs |= rf_rs_en;
    end
    chk({tag, "_latency"}, n, we ? 1 : 2);
    chk({tag, "_rsp_id"}, rsp_id, id);
    chk({tag, "_rsp_err"}, rsp_err, exp_err);
    chk({tag, "_saw_en"}, {saw_wr, saw_rs}, {exp_wr, !we && rsu});
    if (!we && !exp_err) begin
      chk({tag, "_rd_data"}, rsp_rd_data, exp_rd);
      chk({tag, "_rs_data"}, rsp_rs_data, exp_rs);
    end
    $display("txn %s id=%0d we=%0d rd=%0d rs=%0d err=%0b rd_data=%h rs_data=%h",
             tag, id, we, rd, rs, rsp_err, rsp_rd_data, rsp_rs_data);
    @(posedge clk); #1;
  endtask

  initial begin
    int n, ng;
    bit saw_done;
    logic [15:0] snap;
    logic [3:0] gseq;
    rst = 1; req0 = 0; req1 = 0; we0 = 0; we1 = 0; rs_use0 = 0; rs_use1 = 0;
    rd_addr0 = 0; rd_addr1 = 0; rs_addr0 = 0; rs_addr1 = 0; wdata0 = 0; wdata1 = 0;
    rf_valid = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctrl", {gnt0, gnt1, done, rf_wr_en, rf_rd_en, rf_rs_en, rsp_err, rsp_id}, 0);
    chk("reset_data", {rsp_rd_data, rsp_rs_data}, 0);
    rst = 0;
    @(posedge clk); #1;

    op("wr3",   0, 1, 0, 4'd3, 4'd0, 16'h1234, 0, 16'h0, 16'h0);
    op("wr5",   0, 1, 0, 4'd5, 4'd0, 16'h00FF, 0, 16'h0, 16'h0);
    op("rd3_5", 1, 0, 1, 4'd3, 4'd5, 16'h0,    0, 16'h1234, 16'h00FF);

    // Both requesters held: grants must alternate starting with 0.
    req0 = 1; we0 = 1; rs_use0 = 0; rd_addr0 = 4'd6; wdata0 = 16'h0600;
    req1 = 1; we1 = 1; rs_use1 = 0; rd_addr1 = 4'd7; wdata1 = 16'h0700;
    ng = 0; n = 0; gseq = 4'hF;
    while (ng < 4 && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (gnt0 || gnt1) begin gseq[ng] = gnt1; ng++; end
    end
    req0 = 0; req1 = 0;
    chk("rr_count", ng, 4);
    chk("rr_order", {28'd0, gseq}, 32'b1010);
    $display("txn rr grants=%0d order(lsb first)=%b", ng, gseq);
    n = 0;
    while (!done && n < 8) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;

    snap = mem[14];
    op("wr_neg2", 0, 1, 0, 4'b1110, 4'd0, 16'hDEAD, 1, 16'h0, 16'h0);
    chk("wr_neg2_mem", mem[14], snap);
    op("rd7_6",   0, 0, 1, 4'd7, 4'd6, 16'h0, 0, 16'h0700, 16'h0600);
    op("rd3_nors", 1, 0, 0, 4'd3, 4'd5, 16'h0, 0, 16'h1234, 16'h0000);
    op("rs_neg1", 0, 0, 1, 4'd3, 4'b1111, 16'h0, 1, 16'h0, 16'h0);
    rf_valid = 0;
    op("rf_inval", 1, 0, 0, 4'd3, 4'd0, 16'h0, 1, 16'h0, 16'h0);
    rf_valid = 1;

    // Reset during ISSUE of a write from requester 0.
    req0 = 1; we0 = 1; rs_use0 = 0; rd_addr0 = 4'd3; wdata0 = 16'hBEEF;
    @(posedge clk); #1;
    chk("abort_issue", {gnt0, rf_wr_en}, 2'b11);
    req0 = 0;
    #2 rst = 1;
    #1;
    chk("abort_wr_drop", {gnt0, rf_wr_en, done}, 0);
    @(posedge clk); #1;
    rst = 0;
    saw_done = 0;
    for (int i = 0; i < 4; i++) begin @(posedge clk); #1; saw_done |= done; end
    chk("abort_no_done", saw_done, 0);
    chk("abort_mem", mem[3], 16'h1234);
    $display("txn abort reg3=%h", mem[3]);

    // Tie right after reset must go to requester 0.
    req0 = 1; we0 = 0; rs_use0 = 0; rd_addr0 = 4'd3;
    req1 = 1; we1 = 0; rs_use1 = 0; rd_addr1 = 4'd5;
    @(posedge clk); #1;
    chk("post_rst_gnt", {gnt0, gnt1}, 2'b10);
    req0 = 0; req1 = 0;
    n = 0;
    while (!done && n < 8) begin @(posedge clk); #1; n++; end
    chk("post_rst_rsp", {rsp_id, rsp_err, rsp_rd_data}, {2'b00, 16'h1234});
    $display("txn post_rst id=%0d rd_data=%h", rsp_id, rsp_rd_data);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_access_arbiter.md
Name: regfile_access_arbiter

Overview:
- Shares the CPU's single register file between two requesters: requester 0 (core decode/writeback) and requester 1 (debug/loader port).
- Each request is one operation: a write, or a read of one or two registers (rd and, optionally, rs).
- The block arbitrates round-robin, sequences the register file's enables and addresses around its one-cycle read latency, and returns data plus an error flag tagged with the requester ID.

Parameters:
- memoryDepth, 16, number of registers in the register file.
- addressBitWidth, 4, width of a register address (signed).
- dataBitWidth, 16, width of a register (signed).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0, req1  in  1 each  request valid; held high until the matching gnt pulse.
- we0, we1  in  1 each  1 = write wdata to rd_addr; 0 = read.
- rs_use0, rs_use1  in  1 each  on a read, also read rs_addr.
- rd_addr0, rd_addr1  in  addressBitWidth each  signed destination / first-source address.
- rs_addr0, rs_addr1  in  addressBitWidth each  signed second-source address.
- wdata0, wdata1  in  dataBitWidth each  write data.
- gnt0, gnt1  out  1 each  one-cycle pulse: request accepted.
- done  out  1  one-cycle pulse: operation complete, rsp_* valid.
- rsp_id  out  1  requester that owns the current done.
- rsp_rd_data, rsp_rs_data  out  dataBitWidth each  read results.
- rsp_err  out  1  an address was out of range.
- rf_rd_en, rf_rs_en, rf_wr_en  out  1 each  register-file enables.
- rf_rd_addr, rf_rs_addr  out  addressBitWidth each  register-file addresses.
- rf_wr_data  out  dataBitWidth  register-file write data.
- rf_rd_data, rf_rs_data  in  dataBitWidth each  register-file read data.
- rf_valid  in  1  register-file valid flag, sampled in CAPT only.

Behaviour:
- Reset:
  - FSM goes to IDLE and the round-robin pointer is set so requester 0 wins the first tie.
  - All outputs go to 0, including rf_* enables, gnt, done, rsp_* and rsp_err.
  - Reset is asynchronous. Mid-operation, the pending op is abandoned and rf_wr_en drops immediately; no done is issued for it.
- FSM states: IDLE, ISSUE, CAPT, DONE.
- IDLE:
  - If any req is high, pick a winner. One request wins outright; with both high, the requester not granted last wins.
  - Latch the winner's we, rs_use, addresses and wdata; update the pointer; go to ISSUE.
- ISSUE (acceptance cycle + 1):
  - gnt of the winner is high for exactly this cycle.
  - rf_* outputs are registered from the latched request and driven this cycle.
  - Write with rd_addr in 0..memoryDepth-1: rf_wr_en=1, rf_rd_en=rf_rs_en=0.
  - Write with rd_addr out of range (negative or ≥ memoryDepth): rf_wr_en stays 0 and the error is latched.
  - Write goes to DONE next.
  - Read: rf_rd_en=1, rf_rs_en=rs_use, rf_wr_en=0; go to CAPT.
- CAPT (reads only):
  - rf_rd_data, rf_rs_data and rf_valid are valid this cycle.
  - Latch them into rsp_rd_data and rsp_rs_data (rsp_rs_data=0 if rs_use=0).
  - err = !rf_valid, OR'd with a local range check of both used addresses.
  - All rf enables are 0; go to DONE.
- DONE:
  - done=1, rsp_id=owner, rsp_err valid; go to IDLE.
  - rsp_* hold their values until the next done.
  - No rf enable is active.
- Latency, acceptance cycle to done: write 2 cycles, read 3. Throughput: one op per 3 cycles (write) or 4 cycles (read).
- Requester rules:
  - Must drop or change req in the cycle after its gnt. req seen outside IDLE is ignored.
  - A requester may re-request immediately; arbitration happens only in IDLE.
- Atomicity: a register file write and read are never issued in the same cycle, so there are no read-during-write hazards.
- Addresses are treated as signed throughout; the range check is 0 ≤ addr < memoryDepth.
- gnt0 and gnt1 are mutually exclusive. done never coincides with gnt.

Test Plan:
- Reset, then req0 write, rd_addr0=3, wdata0=16'h1234 → gnt0 one cycle later with rf_wr_en=1, rf_rd_addr=3; done next cycle with rsp_id=0, rsp_err=0. A later req1 read of 3 → rsp_rd_data=16'h1234.
- req1 read, rd_addr=3, rs_addr=5, rs_use=1, with register 5 preloaded to 16'h00FF → done 3 cycles after acceptance, rsp_rd_data=16'h1234, rsp_rs_data=16'h00FF, rsp_id=1.
- req0 and req1 held continuously for 4 operations → grants alternate 0,1,0,1 starting with 0; no cycle has both gnt high.
- Write with rd_addr=4'b1110 (−2) → rf_wr_en never asserts, done with rsp_err=1, register contents unchanged. Read with rs_addr=−1 → rsp_err=1.
- Read with rs_use=0 → rf_rs_en=0 throughout, rsp_rs_data=0.
- Assert rst during ISSUE of a write → rf_wr_en drops the same cycle, the target register is unchanged, no done; the next request after reset is granted to requester 0.
